// File: rtl/counter_plus.sv
// counter_plus: prescaled up/down counter with wrap, saturate and one-shot
// modes, sticky overflow flag, compare-match pulse and a DONE state for
// one-shot operation. All outputs come straight from registers.
module counter_plus #(
  parameter int DATA_WIDTH = 16,
  parameter int PSC_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic                  down_i,
  input  logic [1:0]            mode_i,
  input  logic [PSC_WIDTH-1:0]  psc_i,
  input  logic [DATA_WIDTH-1:0] delta_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [DATA_WIDTH-1:0] reload_i,
  input  logic [DATA_WIDTH-1:0] cmp_i,
  input  logic                  ovf_clr_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ovf_o,
  output logic                  cmp_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [PSC_WIDTH-1:0]  PSC_ZERO  = {PSC_WIDTH{1'b0}};
  localparam logic [PSC_WIDTH-1:0]  PSC_ONE   = PSC_WIDTH'(1'b1);

  // Up-step computed one bit wider so the carry out is the overflow flag.
  function automatic logic [DATA_WIDTH:0] add_ext(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Down-step borrows exactly when the step exceeds the current value.
  function automatic logic borrow_out(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return (b > a);
  endfunction

  // Registered state
  state_t                  state_r;
  logic [PSC_WIDTH-1:0]    psc_cnt_r;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ovf_r;
  logic                    cmp_r;
  logic                    done_r;

  // Next-state values
  state_t                  state_s;
  logic [PSC_WIDTH-1:0]    psc_cnt_s;
  logic [DATA_WIDTH-1:0]   dat_s;
  logic                    ovf_s;
  logic                    cmp_s;
  logic                    done_s;

  // Datapath helpers
  logic                    tick_s;
  logic [DATA_WIDTH:0]     sum_s;
  logic [DATA_WIDTH-1:0]   raw_s;
  logic [DATA_WIDTH-1:0]   sat_s;
  logic                    boundary_s;
  logic [DATA_WIDTH-1:0]   step_val_s;
  logic                    enter_done_s;

  // Prescaler tick: only while running and enabled; >= keeps ticking if psc_i shrinks.
  always_comb begin
    tick_s = 1'b0;
    if ((state_r == ST_RUN) && en_i && (psc_cnt_r >= psc_i)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Raw step result, boundary detection and the clamp value for saturation.
  always_comb begin
    sum_s      = add_ext(dat_r, delta_i);
    raw_s      = DATA_ZERO;
    sat_s      = DATA_ZERO;
    boundary_s = 1'b0;
    if (down_i) begin
      raw_s      = dat_r - delta_i;
      sat_s      = DATA_ZERO;
      boundary_s = borrow_out(dat_r, delta_i);
    end else begin
      raw_s      = sum_s[DATA_WIDTH-1:0];
      sat_s      = DATA_ONES;
      boundary_s = sum_s[DATA_WIDTH];
    end
  end

  // Value a tick produces, depending on mode and whether the boundary was crossed.
  always_comb begin
    step_val_s   = raw_s;
    enter_done_s = 1'b0;
    case (mode_i)
      MODE_SAT: begin
        if (boundary_s) begin
          step_val_s = sat_s;
        end else begin
          step_val_s = raw_s;
        end
      end
      MODE_ONESHOT: begin
        if (boundary_s) begin
          step_val_s   = reload_i;
          enter_done_s = 1'b1;
        end else begin
          step_val_s   = raw_s;
        end
      end
      MODE_WRAP, MODE_RSVD: begin
        if (boundary_s) begin
          step_val_s = reload_i;
        end else begin
          step_val_s = raw_s;
        end
      end
      default: begin
        step_val_s = raw_s;
      end
    endcase
  end

  // Next-state and next-output logic: clr > load > step (reset is in the register).
  always_comb begin
    state_s   = state_r;
    psc_cnt_s = psc_cnt_r;
    dat_s     = dat_r;
    cmp_s     = 1'b0;
    if (ovf_clr_i) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end

    if (clr_i) begin
      state_s   = ST_IDLE;
      psc_cnt_s = PSC_ZERO;
      dat_s     = DATA_ZERO;
      ovf_s     = 1'b0;
    end else if (load_i) begin
      // A load swallows any tick of this cycle and never flags anything.
      dat_s     = dat_i;
      psc_cnt_s = PSC_ZERO;
      if (en_i) begin
        state_s = ST_RUN;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en_i) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state_s = ST_IDLE;
          end else if (tick_s) begin
            psc_cnt_s = PSC_ZERO;
            dat_s     = step_val_s;
            cmp_s     = (step_val_s == cmp_i);
            if (boundary_s) begin
              // Setting the sticky flag beats a simultaneous ovf_clr_i.
              ovf_s = 1'b1;
            end else begin
              ovf_s = ovf_s;
            end
            if (enter_done_s) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            psc_cnt_s = psc_cnt_r + PSC_ONE;
            state_s   = ST_RUN;
          end
        end
        ST_DONE: begin
          // Parked until clr, load or reset; en_i has no effect here.
          state_s = ST_DONE;
        end
        default: begin
          state_s   = ST_IDLE;
          psc_cnt_s = PSC_ZERO;
          dat_s     = DATA_ZERO;
        end
      endcase
    end

    done_s = (state_s == ST_DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      psc_cnt_r <= PSC_ZERO;
      dat_r     <= DATA_ZERO;
      ovf_r     <= 1'b0;
      cmp_r     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      psc_cnt_r <= psc_cnt_s;
      dat_r     <= dat_s;
      ovf_r     <= ovf_s;
      cmp_r     <= cmp_s;
      done_r    <= done_s;
    end
  end

  assign dat_o  = dat_r;
  assign ovf_o  = ovf_r;
  assign cmp_o  = cmp_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_counter_plus.sv
// Self-checking bench for counter_plus (DATA_WIDTH=8, PSC_WIDTH=4).
// A behavioural model built from integer arithmetic tracks the expected
// outputs; a negedge process compares them every cycle, and directed
// sequences add hand-computed literal checks on both DUT and model.
module tb_counter_plus;

  logic       clk;
  logic       rst, clr, en, load, down, ovf_clr;
  logic [1:0] mode;
  logic [3:0] psc;
  logic [7:0] delta, dat, reload, cmp;
  logic [7:0] dat_q;
  logic       ovf_q, cmp_q, done_q;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  counter_plus #(.DATA_WIDTH(8), .PSC_WIDTH(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (clr),
    .en_i     (en),
    .load_i   (load),
    .down_i   (down),
    .mode_i   (mode),
    .psc_i    (psc),
    .delta_i  (delta),
    .dat_i    (dat),
    .reload_i (reload),
    .cmp_i    (cmp),
    .ovf_clr_i(ovf_clr),
    .dat_o    (dat_q),
    .ovf_o    (ovf_q),
    .cmp_o    (cmp_q),
    .done_o   (done_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: integer value, flags and a count of enabled cycles.
  typedef struct {
    int val;
    bit ovf;
    bit cmp;
    bit running;
    bit finished;
    int pcount;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t model_next(model_t cur);
    model_t n;
    int     nv;
    bit     crossed;
    n       = cur;
    n.cmp   = 1'b0;
    n.ovf   = cur.ovf && !ovf_clr;
    if (rst) begin
      n = '{default: 0};
    end else if (clr) begin
      n = '{default: 0};
    end else if (load) begin
      n.val      = int'(dat);
      n.pcount   = 0;
      n.finished = 1'b0;
      n.running  = en;
    end else if (cur.finished) begin
      n.finished = 1'b1;
    end else if (!cur.running) begin
      n.running = en;
    end else if (!en) begin
      n.running = 1'b0;
    end else if (cur.pcount >= int'(psc)) begin
      n.pcount = 0;
      nv       = down ? (cur.val - int'(delta)) : (cur.val + int'(delta));
      crossed  = (nv < 0) || (nv > 255);
      if (!crossed) begin
        n.val = nv;
      end else if (mode == 2'd1) begin
        n.val = down ? 0 : 255;
      end else if (mode == 2'd2) begin
        n.val      = int'(reload);
        n.finished = 1'b1;
        n.running  = 1'b0;
      end else begin
        n.val = int'(reload);
      end
      if (crossed) n.ovf = 1'b1;
      n.cmp = (n.val == int'(cmp));
    end else begin
      n.pcount = cur.pcount + 1;
    end
    return n;
  endfunction

  // Advance the model on every rising edge from the inputs the DUT sees.
  always @(posedge clk) m <= model_next(m);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dat_o",  int'(dat_q),  m.val);
      check("ovf_o",  int'(ovf_q),  int'(m.ovf));
      check("cmp_o",  int'(cmp_q),  int'(m.cmp));
      check("done_o", int'(done_q), int'(m.finished));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Literal expectation on dat_o, also pinning the model to the same value.
  task automatic lit_dat(input string name, input int exp);
    check(name, int'(dat_q), exp);
    check({name, "_model"}, m.val, exp);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; load = 1'b0; down = 1'b0; ovf_clr = 1'b0;
    mode = 2'd0; psc = 4'd0; delta = 8'd1; dat = 8'd0; reload = 8'd0; cmp = 8'd0;
    cyc(2);
    chk_en = 1'b1;
    lit_dat("reset_dat", 0);
    check("reset_ovf", int'(ovf_q), 0);
    check("reset_done", int'(done_q), 0);
    check("reset_cmp", int'(cmp_q), 0);
    rst = 1'b0;

    // Wrap up with auto-reload
    reload = 8'h10; dat = 8'hFE; load = 1'b1; en = 1'b1;
    cyc(1); load = 1'b0;
    lit_dat("wrap_load", 8'hFE);
    cyc(1); lit_dat("wrap_ff", 8'hFF); check("wrap_ovf0", int'(ovf_q), 0);
    cyc(1); lit_dat("wrap_10", 8'h10); check("wrap_ovf1", int'(ovf_q), 1);
    cyc(1); lit_dat("wrap_11", 8'h11); check("wrap_ovf_sticky", int'(ovf_q), 1);
    ovf_clr = 1'b1;
    cyc(1); ovf_clr = 1'b0;
    lit_dat("wrap_12", 8'h12); check("wrap_ovf_clr", int'(ovf_q), 0);

    // Reset in the middle of a run
    dat = 8'h40; load = 1'b1;
    cyc(1); load = 1'b0; lit_dat("rst_pre", 8'h40);
    rst = 1'b1;
    cyc(1); rst = 1'b0; en = 1'b0;
    lit_dat("rst_dat", 0);
    check("rst_ovf", int'(ovf_q), 0);
    check("rst_done", int'(done_q), 0);
    cyc(2); lit_dat("rst_idle_hold", 0);
    en = 1'b1;
    cyc(1); lit_dat("rst_idle_to_run", 0);
    cyc(1); lit_dat("rst_first_step", 1);

    // Prescaler, including psc shrinking mid-count
    clr = 1'b1;
    cyc(1); clr = 1'b0;
    psc = 4'd3; delta = 8'd2; dat = 8'd0; load = 1'b1;
    cyc(1); load = 1'b0;
    cyc(3); lit_dat("psc_hold", 0);
    cyc(1); lit_dat("psc_step1", 2);
    cyc(8); lit_dat("psc_step3", 6);
    cyc(2); psc = 4'd0;
    cyc(1); lit_dat("psc_shrink", 8);
    cyc(1); lit_dat("psc_fast", 8'h0A);

    // Saturating down count
    mode = 2'd1; down = 1'b1; delta = 8'd3; dat = 8'd5; load = 1'b1; ovf_clr = 1'b1;
    cyc(1); load = 1'b0; ovf_clr = 1'b0;
    lit_dat("sat_load", 5);
    cyc(1); lit_dat("sat_2", 2); check("sat_ovf0", int'(ovf_q), 0);
    cyc(1); lit_dat("sat_0a", 0); check("sat_ovf1", int'(ovf_q), 1);
    cyc(1); lit_dat("sat_0b", 0);
    cyc(1); lit_dat("sat_0c", 0); check("sat_done", int'(done_q), 0);

    // One-shot down with compare and reload
    mode = 2'd2; delta = 8'd1; reload = 8'd9; cmp = 8'd1; dat = 8'd3; load = 1'b1; ovf_clr = 1'b1;
    cyc(1); load = 1'b0; ovf_clr = 1'b0;
    lit_dat("os_load", 3);
    cyc(1); lit_dat("os_2", 2); check("os_cmp_2", int'(cmp_q), 0);
    cyc(1); lit_dat("os_1", 1); check("os_cmp_1", int'(cmp_q), 1);
    cyc(1); lit_dat("os_0", 0); check("os_cmp_0", int'(cmp_q), 0);
    cyc(1); lit_dat("os_9", 9); check("os_done", int'(done_q), 1); check("os_ovf", int'(ovf_q), 1);
    cyc(3); lit_dat("os_hold", 9); check("os_done_hold", int'(done_q), 1);
    dat = 8'd4; load = 1'b1;
    cyc(1); load = 1'b0;
    lit_dat("os_reload", 4); check("os_done_exit", int'(done_q), 0);
    cyc(1); lit_dat("os_resume", 3);

    // Reserved mode behaves as wrap
    mode = 2'd3; down = 1'b0; delta = 8'h10; reload = 8'h05; cmp = 8'hFF; dat = 8'hF8;
    load = 1'b1; ovf_clr = 1'b1;
    cyc(1); load = 1'b0; ovf_clr = 1'b0;
    lit_dat("rsvd_load", 8'hF8);
    cyc(1); lit_dat("rsvd_wrap", 5); check("rsvd_ovf", int'(ovf_q), 1);

    // ovf set collides with ovf_clr: set wins
    mode = 2'd0; delta = 8'd1; reload = 8'h20; dat = 8'hFF; load = 1'b1; ovf_clr = 1'b1;
    cyc(1); load = 1'b0;
    check("coll_ovf_cleared", int'(ovf_q), 0);
    cyc(1); lit_dat("coll_wrap", 8'h20); check("coll_set_wins", int'(ovf_q), 1);
    cyc(1); lit_dat("coll_next", 8'h21); check("coll_clr_after", int'(ovf_q), 0);
    ovf_clr = 1'b0;

    // clr and load together: clr wins, lands in IDLE
    clr = 1'b1; load = 1'b1; dat = 8'h77;
    cyc(1); clr = 1'b0; load = 1'b0;
    lit_dat("clr_load", 0);
    cyc(1); lit_dat("clr_idle", 0);
    cyc(1); lit_dat("clr_run", 1);

    // Zero step: no change, no ovf, compare still pulses
    delta = 8'd0; cmp = 8'd1;
    cyc(1); lit_dat("zero_step", 1); check("zero_cmp", int'(cmp_q), 1); check("zero_ovf", int'(ovf_q), 0);
    cyc(1); check("zero_cmp2", int'(cmp_q), 1);

    // Load collides with a tick: load wins
    delta = 8'd5; dat = 8'h30; load = 1'b1;
    cyc(1); load = 1'b0;
    lit_dat("load_tick", 8'h30); check("load_tick_cmp", int'(cmp_q), 0);
    cyc(1); lit_dat("after_load", 8'h35);

    cyc(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
